// File: rtl/operand_deserializer_pkg.sv
// Shared types and sizing helpers for the operand deserializer.
package deser_pkg;

  localparam int W_DEF = 16;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} deser_state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/operand_deserializer_lane_shift.sv
// One serial lane: W-bit MSB-first shift register with a synchronous
// load-of-first-bit that restarts the word.
module lane_shift
  import deser_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         load_first,
  input  logic         din_bit,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  assign q = q_r;

  // Shift register; a new frame start overrides shifting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= {W{1'b0}};
    end else if (load_first) begin
      q_r <= {{(W-1){1'b0}}, din_bit};
    end else if (shift_en) begin
      q_r <= {q_r[W-2:0], din_bit};
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/operand_deserializer.sv
// Two-lane serial-to-parallel operand capture with a one-entry output
// buffer, framing-error pulse and sticky overrun flag.
module operand_deserializer
  import deser_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   din,
  input  logic         din_valid,
  input  logic         sof,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun,
  input  logic         clr_overrun
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  deser_state_t   state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic           start_s, shift_s, done_s, abort_s, drop_s;
  logic [W-1:0]   sr_a_r, sr_b_r;
  logic [W-1:0]   word_a_s, word_b_s;
  logic [W-1:0]   a_r, b_r;
  logic           out_valid_r, frame_err_r, overrun_r;
  logic           unused_msb_s;

  assign start_s  = din_valid & sof;
  assign shift_s  = din_valid & ~sof & (state_r == SHIFT);
  assign done_s   = shift_s & (cnt_r == CNT_LAST);
  assign abort_s  = start_s & (state_r == SHIFT);
  assign drop_s   = done_s & out_valid_r & ~out_ready;

  // The completed word includes the bit arriving this cycle.
  assign word_a_s = {sr_a_r[W-2:0], din[0]};
  assign word_b_s = {sr_b_r[W-2:0], din[1]};
  assign unused_msb_s = sr_a_r[W-1] ^ sr_b_r[W-1];

  lane_shift #(.W(W)) u_lane_a (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_s), .load_first(start_s),
    .din_bit(din[0]), .q(sr_a_r)
  );

  lane_shift #(.W(W)) u_lane_b (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_s), .load_first(start_s),
    .din_bit(din[1]), .q(sr_b_r)
  );

  // FSM state and received-bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = CW'(1);
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      SHIFT: begin
        if (start_s) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = CW'(1);
        end else if (done_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end else if (shift_s) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = cnt_r + CW'(1);
        end else begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output buffer: a full buffer may be refilled only if drained this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (done_s && (!out_valid_r || out_ready)) begin
      a_r         <= word_a_s;
      b_r         <= word_b_s;
      out_valid_r <= 1'b1;
    end else if (!done_s && out_valid_r && out_ready) begin
      a_r         <= a_r;
      b_r         <= b_r;
      out_valid_r <= 1'b0;
    end else begin
      a_r         <= a_r;
      b_r         <= b_r;
      out_valid_r <= out_valid_r;
    end
  end

  // Status flags; a fresh drop wins over a clear request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= abort_s;
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_overrun) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign a         = a_r;
  assign b         = b_r;
  assign out_valid = out_valid_r;
  assign busy      = (state_r == SHIFT);
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_operand_deserializer.sv
// Self-checking bench: directed vectors, corner sequences and random traffic
// compared against a queue-based frame model.
module tb_operand_deserializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   din = 2'b00;
  logic         din_valid = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy, frame_err, overrun;
  logic         clr_overrun = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_seen = 0;

  operand_deserializer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_err(frame_err), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the frame in progress kept as queues.
  bit           mq_a[$];
  bit           mq_b[$];
  bit           m_in = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  bit           m_valid = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;

  function automatic logic [W-1:0] pack(input bit q[$]);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) w[W-1-i] = q[i];
    return w;
  endfunction

  task automatic model_step(input bit dv, input bit s, input bit [1:0] d,
                            input bit rdy, input bit clr, input bit rstn);
    bit done, new_ovr;
    logic [W-1:0] wa, wb;
    done = 1'b0; wa = '0; wb = '0; m_fe = 1'b0;
    if (!rstn) begin
      mq_a.delete(); mq_b.delete();
      m_in = 1'b0; m_a = '0; m_b = '0; m_valid = 1'b0; m_ovr = 1'b0;
      return;
    end
    if (dv) begin
      if (s) begin
        if (m_in) m_fe = 1'b1;
        mq_a.delete(); mq_b.delete();
        mq_a.push_back(d[0]); mq_b.push_back(d[1]);
        m_in = 1'b1;
      end else if (m_in) begin
        mq_a.push_back(d[0]); mq_b.push_back(d[1]);
        if (mq_a.size() == W) begin
          done = 1'b1; wa = pack(mq_a); wb = pack(mq_b);
          m_in = 1'b0;
        end
      end
    end
    new_ovr = done && m_valid && !rdy;
    if (done && !new_ovr) begin
      m_a = wa; m_b = wb; m_valid = 1'b1;
    end else if (!done && m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (new_ovr) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit dv, input bit s, input bit [1:0] d,
                      input bit rdy, input bit clr, input bit rstn);
    logic [63:0] got, exp;
    din_valid = dv; sof = s; din = d; out_ready = rdy;
    clr_overrun = clr; rst_n = rstn;
    model_step(dv, s, d, rdy, clr, rstn);
    @(posedge clk);
    #1;
    if (frame_err === 1'b1) ferr_seen++;
    got = {28'd0, a, b, out_valid, busy, frame_err, overrun};
    exp = {28'd0, m_a, m_b, m_valid, m_in, m_fe, m_ovr};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL model_cycle: got %h expected %h at %0t", got, exp, $time);
    end
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 2'b00, rdy, 1'b0, 1'b1);
  endtask

  task automatic send_word(input logic [W-1:0] la, input logic [W-1:0] lb,
                           input bit gap, input bit rdy_body, input bit rdy_last);
    for (int i = 0; i < W; i++) begin
      if (gap && i > 0) begin
        step(1'b0, 1'b0, 2'($urandom), rdy_body, 1'b0, 1'b1);
        chk("busy_gap", {31'd0, busy}, 32'd1);
      end
      step(1'b1, (i == 0), {lb[W-1-i], la[W-1-i]},
           (i == W-1) ? rdy_last : rdy_body, 1'b0, 1'b1);
    end
  endtask

  typedef struct {
    logic [W-1:0] la;
    logic [W-1:0] lb;
    bit           gap;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'hA5C3, 16'h0F0F, 1'b0, 16'hA5C3, 16'h0F0F};
    vecs[1] = '{16'hA5C3, 16'h0F0F, 1'b1, 16'hA5C3, 16'h0F0F};
    vecs[2] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};

    // Reset state
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("reset_outs", {a, b}, 32'h0);
    chk("reset_flags", {28'd0, out_valid, busy, frame_err, overrun}, 32'h0);
    idle(1'b1);

    // Single and gapped words: one-cycle out_valid right after the last bit
    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].la, vecs[v].lb, vecs[v].gap, 1'b1, 1'b1);
      chk("vec_ab", {a, b}, {vecs[v].ea, vecs[v].eb});
      chk("vec_valid", {31'd0, out_valid}, 32'd1);
      chk("vec_busy_end", {31'd0, busy}, 32'd0);
      idle(1'b1);
      chk("vec_valid_1cyc", {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: second word dropped, overrun set then cleared
    send_word(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    chk("bp_first", {a, b}, 32'h1234_4321);
    send_word(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("bp_hold", {a, b}, 32'h1234_4321);
    chk("bp_overrun", {31'd0, overrun}, 32'd1);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("ovr_clear", {31'd0, overrun}, 32'd0);

    // Accept and load in the same cycle
    send_word(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    chk("acc_load_ab", {a, b}, 32'hFFFF_0001);
    chk("acc_load_ovr", {31'd0, overrun}, 32'd0);
    chk("acc_load_valid", {31'd0, out_valid}, 32'd1);
    idle(1'b1);

    // Early sof after 7 bits
    ferr_seen = 0;
    for (int i = 0; i < 7; i++) step(1'b1, (i == 0), 2'($urandom), 1'b1, 1'b0, 1'b1);
    send_word(16'h8001, 16'h7FFE, 1'b0, 1'b1, 1'b1);
    chk("early_sof_ferr", 32'(ferr_seen), 32'd1);
    chk("early_sof_ab", {a, b}, 32'h8001_7FFE);

    // Reset mid-frame after 9 bits with the buffer still full
    for (int i = 0; i < 9; i++) step(1'b1, (i == 0), 2'($urandom), 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("midrst_ab", {a, b}, 32'h0);
    chk("midrst_flags", {28'd0, out_valid, busy, frame_err, overrun}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 2'($urandom), 1'b1, 1'b0, 1'b1);
      chk("midrst_noout", {30'd0, out_valid, busy}, 32'h0);
    end

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bit dv, s, rdy, clr, rstn;
      dv   = ($urandom_range(3) != 0);
      s    = m_in ? ($urandom_range(39) == 0) : ($urandom_range(2) == 0);
      rdy  = ($urandom_range(2) != 0);
      clr  = ($urandom_range(15) == 0);
      rstn = ($urandom_range(499) != 0);
      step(dv, s, 2'($urandom), rdy, clr, rstn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
